// File: rtl/apb_timer_array.sv
// apb_timer_array: NUM_CH independent CNT_W-bit up/down timers on one
// zero-wait-state APB slave, each with prescaler, auto-reload and irq.
//
// Ports:
//   pclk, presetn          clock, async active-low reset
//   psel, penable, pwrite  APB control
//   paddr, pwdata          APB address (ch = paddr[ADDR_W-1:4]) / write data
//   prdata, pready,        APB read data, completion, error
//   pslverr
//   irq[NUM_CH], irq_any   per-channel interrupt and their OR
module apb_timer_array #(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 8,
    parameter int ADDR_W = 8
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    output logic [NUM_CH-1:0] irq,
    output logic              irq_any
);
    localparam int CH_W = ADDR_W - 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic              access;
    logic              wr_ok;
    logic [CH_W-1:0]   ch_idx;
    logic [1:0]        reg_off;
    logic [NUM_CH-1:0] ch_sel;
    logic              ch_hit;
    logic [31:0]       rdata;
    logic              unused_bits;

    logic [NUM_CH-1:0] en, dir, arl;
    logic [NUM_CH-1:0] ovf, udf, ovf_ie, udf_ie;
    logic [2:0]        div [NUM_CH];
    logic [6:0]        psc [NUM_CH];
    logic [CNT_W-1:0]  tdr [NUM_CH];
    logic [CNT_W-1:0]  cnt [NUM_CH];

    logic [NUM_CH-1:0] tcr_wr, tdr_wr, tsr_wr;
    logic [NUM_CH-1:0] load, tick;
    logic [NUM_CH-1:0] ovf_set, udf_set;
    logic [6:0]        psc_mask [NUM_CH];
    logic [CNT_W-1:0]  cnt_nxt [NUM_CH];

    assign access      = psel & penable;
    assign ch_idx      = paddr[ADDR_W-1:4];
    assign reg_off     = paddr[3:2];
    assign unused_bits = ^{paddr[1:0], pwdata};

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_sel[i] = (ch_idx == CH_W'(i));
        end
    end

    assign ch_hit = |ch_sel;
    assign wr_ok  = access & pwrite & ch_hit;

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            tcr_wr[i]   = wr_ok & ch_sel[i] & (reg_off == 2'd0);
            tdr_wr[i]   = wr_ok & ch_sel[i] & (reg_off == 2'd1);
            tsr_wr[i]   = wr_ok & ch_sel[i] & (reg_off == 2'd3);
            load[i]     = tcr_wr[i] & pwdata[2];
            // Low DIV bits of the prescaler all ones => tick.
            psc_mask[i] = 7'h7F >> (3'd7 - div[i]);
            tick[i]     = en[i] & ~load[i]
                        & ((psc[i] & psc_mask[i]) == psc_mask[i]);
            cnt_nxt[i]  = cnt[i];
            ovf_set[i]  = 1'b0;
            udf_set[i]  = 1'b0;
            if (load[i]) begin
                cnt_nxt[i] = tdr[i];
            end else if (tick[i]) begin
                if (!dir[i]) begin
                    if (cnt[i] == CNT_MAX) begin
                        cnt_nxt[i] = arl[i] ? tdr[i] : '0;
                        ovf_set[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] + CNT_W'(1);
                    end
                end else begin
                    if (cnt[i] == '0) begin
                        cnt_nxt[i] = arl[i] ? tdr[i] : CNT_MAX;
                        udf_set[i] = 1'b1;
                    end else begin
                        cnt_nxt[i] = cnt[i] - CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            en     <= '0;
            dir    <= '0;
            arl    <= '0;
            ovf    <= '0;
            udf    <= '0;
            ovf_ie <= '0;
            udf_ie <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                div[i] <= '0;
                psc[i] <= '0;
                tdr[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (tcr_wr[i]) begin
                    en[i]  <= pwdata[0];
                    dir[i] <= pwdata[1];
                    arl[i] <= pwdata[3];
                    div[i] <= pwdata[6:4];
                end
                if (tdr_wr[i]) begin
                    tdr[i] <= pwdata[CNT_W-1:0];
                end
                if (tsr_wr[i]) begin
                    ovf_ie[i] <= pwdata[8];
                    udf_ie[i] <= pwdata[9];
                end
                if (!en[i] || load[i] ||
                    (tcr_wr[i] && pwdata[6:4] != div[i])) begin
                    psc[i] <= '0;
                end else begin
                    psc[i] <= psc[i] + 7'd1;
                end
                cnt[i] <= cnt_nxt[i];
                // Hardware set wins over a same-cycle W1C.
                ovf[i] <= (ovf[i] & ~(tsr_wr[i] & pwdata[0])) | ovf_set[i];
                udf[i] <= (udf[i] & ~(tsr_wr[i] & pwdata[1])) | udf_set[i];
            end
        end
    end

    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (ch_sel[i]) begin
                case (reg_off)
                    2'd0: rdata[6:0] = {div[i], arl[i], 1'b0, dir[i], en[i]};
                    2'd1: rdata[CNT_W-1:0] = tdr[i];
                    2'd2: rdata[CNT_W-1:0] = cnt[i];
                    default: rdata[9:0] = {udf_ie[i], ovf_ie[i], 6'b0,
                                           udf[i], ovf[i]};
                endcase
            end
        end
    end

    // Bus outputs are forced low while reset is held.
    assign pready  = presetn & access;
    assign prdata  = (presetn & access & ch_hit) ? rdata : '0;
    assign pslverr = presetn & access
                   & (~ch_hit | (pwrite & (reg_off == 2'd2)));

    assign irq     = (ovf & ovf_ie) | (udf & udf_ie);
    assign irq_any = |irq;

endmodule

// File: doc/apb_timer_array.md
# apb_timer_array

Parametrised APB timer subsystem: `NUM_CH` independent `CNT_W`-bit up/down counters behind one zero-wait-state APB slave. Each channel has a power-of-two prescaler, optional auto-reload, overflow and underflow flags, and a per-channel interrupt. It supersedes the single 8-bit timer and runs entirely in the `pclk` domain, with no separate kernel clock.

## Interface
Parameters:
- `NUM_CH`, 4: channel count, 1..8.
- `CNT_W`, 8: counter width, 2..32.
- `ADDR_W`, 8: APB address width; must cover `NUM_CH*0x10`.

Ports:
- `pclk` in 1: sole clock; all state on rising edge.
- `presetn` in 1: asynchronous, active-low reset.
- `psel`, `penable`, `pwrite` in 1: APB control.
- `paddr` in `ADDR_W`: byte address; bits [1:0] ignored.
- `pwdata` in 32: write data.
- `prdata` out 32: read data.
- `pready` out 1: transfer complete.
- `pslverr` out 1: transfer error.
- `irq` out `NUM_CH`: per-channel interrupt.
- `irq_any` out 1: OR of `irq`.

## Operation
Channel n decodes at base `n*0x10`:
- 0x0 TCR, RW:
  - [0] EN.
  - [1] DIR: 0 = up, 1 = down.
  - [2] LOAD: write-1 pulse, reads 0.
  - [3] ARL: auto-reload.
  - [6:4] DIV: tick every 2^DIV pclk.
  - Other bits RAZ/WI.
- 0x4 TDR, RW: [CNT_W-1:0] load/reload value; upper bits RAZ/WI.
- 0x8 TCNT, RO: live counter value. A write sets `pslverr` and has no effect.
- 0xC TSR:
  - [0] OVF, W1C.
  - [1] UDF, W1C.
  - [8] OVF_IE, RW.
  - [9] UDF_IE, RW.
  - Others RAZ/WI.
- Channel index ≥ NUM_CH, or offset outside these four registers: `pslverr=1`, reads return 0, writes are ignored.

Register resets: all registers 0.

Counting behaviour:
- Prescaler: `DIV`-bit free counter, runs only while EN=1.
  - Tick fires when the low DIV bits are all ones; DIV=0 ticks every cycle.
  - Cleared on: EN=0, write to TCR.DIV with a changed value, LOAD.
- On tick, up direction:
  - Below max: count+1.
  - At `2^CNT_W-1`: count becomes 0 (ARL=0) or TDR (ARL=1), and OVF is set.
- On tick, down direction:
  - Above 0: count-1.
  - At 0: count becomes `2^CNT_W-1` (ARL=0) or TDR (ARL=1), and UDF is set.
- LOAD: TCNT←TDR on the edge ending the write, regardless of EN.
  - If the same write also changes TDR, the new TDR value is loaded.
  - LOAD suppresses a tick in that cycle.
- EN=0: TCNT holds its value.
- DIR change takes effect from the next tick; count is not altered.
- Interrupts: `irq[n] = (OVF&OVF_IE)|(UDF&UDF_IE)`, formed from registered bits with no added delay.

Simultaneous events:
- Hardware set and W1C of the same flag in the same cycle: set wins.
- Writing OVF_IE=1 while OVF=1 raises `irq` the next cycle.

## Timing
- APB: `pready = psel & penable`, so there are no wait states.
- `pslverr` and `prdata` are valid only when `psel & penable`; they are 0 otherwise.
- Register writes commit on the rising edge where `psel & penable & pwrite`.
- `prdata` is combinational from the current register and counter state.
  - A TCNT read returns the value before that edge's update.
- Tick latency: EN written 1 at edge E gives the first count change at edge E+2^DIV.
  - Flag and `irq` assert on the same edge as the wrap.
- Reset mid-operation: all counters, prescalers, flags, registers, `irq`, `irq_any`, `prdata`, `pready` and `pslverr` go to 0 immediately.
  - After release, a channel stays idle until software writes EN=1.
- Counter arithmetic is modulo 2^CNT_W. TDR upper bits beyond CNT_W are discarded on write.
- Channels are fully independent: an access to one channel never perturbs another channel's prescaler or count.

## Test plan
Configuration for all scenarios: NUM_CH=4, CNT_W=8.
- Reset defaults: read all 16 offsets → 0, `pslverr`=0, `irq`=0. Read 0x40 → `pslverr`=1, data 0.
- Up count, ch0: TDR=0xFA, LOAD, TCR=EN|DIV=2 → TCNT steps every 4 pclk. After 24 cycles it wraps to 0x00, OVF=1. With OVF_IE=1, `irq[0]` and `irq_any` go high. W1C OVF → `irq[0]` low the next cycle.
- Down auto-reload, ch2: TDR=0x03, LOAD, TCR=EN|DIR|ARL, DIV=0 → sequence 3,2,1,0,3,2…. UDF sets on each 0→3 transition, with `irq[2]` asserted when UDF_IE=1. Channels 0, 1 and 3 stay at 0.
- Collisions: W1C OVF in the same cycle as a wrap → OVF remains 1. LOAD with EN=1 and DIV=0 → TCNT equals TDR, not TDR+1.
- Error and stop behaviour:
  - Write 0x55 to ch1 TCNT → `pslverr`=1, TCNT unchanged.
  - Clear EN mid-count at 0x37 → holds 0x37. Re-enable with DIV=3 → next step 8 cycles later.
- Reset in flight: assert `presetn` low while ch3 is counting with OVF=1 → all outputs 0 asynchronously. After release, TCNT stays 0 with no ticks.
